// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the two-port main-memory arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port that did not win last.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_idx
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_idx   = PORT_I;
    if (req0 && req1) begin
      gnt_idx = ~last;
    end else if (req1) begin
      gnt_idx = PORT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one slow main-memory port between I-cache (port 0) and D-cache (port 1),
// sequencing each single-word access over MEM_LATENCY wait cycles with a one-cycle ack.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY  = 50,
  parameter int MEM_ADDR_LEN = 13
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0,
  input  logic                    req1,
  input  logic                    we0,
  input  logic                    we1,
  input  logic [31:0]             addr0,
  input  logic [31:0]             addr1,
  input  logic [31:0]             wdata0,
  input  logic [31:0]             wdata1,
  output logic [31:0]             rdata0,
  output logic [31:0]             rdata1,
  output logic                    ack0,
  output logic                    ack1,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [MEM_ADDR_LEN-1:0] mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  output logic                    busy,
  output logic [31:0]             cnt_gnt0,
  output logic [31:0]             cnt_gnt1,
  output logic [31:0]             cnt_conflict
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_LATENCY - 1);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        wait_cnt;
  logic                    wait_last;
  logic                    last;
  logic                    lat_port;
  logic                    lat_we;
  logic [MEM_ADDR_LEN-1:0] lat_addr;
  logic [31:0]             lat_wdata;
  logic                    gnt_valid;
  logic                    gnt_idx;

  rr_arb2 u_rr_arb2 (
    .req0      (req0),
    .req1      (req1),
    .last      (last),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign wait_last = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    busy      = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (gnt_valid) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        mem_en = 1'b1;
        mem_we = lat_we;
        busy   = 1'b1;
        if (wait_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        ack0      = (lat_port == PORT_I);
        ack1      = (lat_port == PORT_D);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Address/data come straight from the latches so every WAIT cycle presents the same access.
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt     <= '0;
      last         <= PORT_I;
      lat_port     <= PORT_I;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      rdata0       <= '0;
      rdata1       <= '0;
      cnt_gnt0     <= '0;
      cnt_gnt1     <= '0;
      cnt_conflict <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            lat_port  <= gnt_idx;
            lat_we    <= gnt_idx ? we1 : we0;
            lat_addr  <= gnt_idx ? addr1[MEM_ADDR_LEN+1:2] : addr0[MEM_ADDR_LEN+1:2];
            lat_wdata <= gnt_idx ? wdata1 : wdata0;
            wait_cnt  <= '0;
            last      <= gnt_idx;
            if (gnt_idx == PORT_D) cnt_gnt1 <= cnt_gnt1 + 32'd1;
            else                   cnt_gnt0 <= cnt_gnt0 + 32'd1;
            if (req0 && req1) cnt_conflict <= cnt_conflict + 32'd1;
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          // Sync RAM data for the held address is stable by the last wait cycle.
          if (wait_last && !lat_we) begin
            if (lat_port == PORT_D) rdata1 <= mem_rdata;
            else                    rdata0 <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LATENCY=3 and a sync-RAM model.
module tb_mem_port_arbiter;

  localparam int L  = 3;
  localparam int AW = 13;

  logic          clk, rst;
  logic          req0, req1, we0, we1;
  logic [31:0]   addr0, addr1, wdata0, wdata1;
  logic [31:0]   rdata0, rdata1;
  logic          ack0, ack1;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          busy;
  logic [31:0]   cnt_gnt0, cnt_gnt1, cnt_conflict;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  mem_port_arbiter #(.MEM_LATENCY(L), .MEM_ADDR_LEN(AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .rdata0(rdata0), .rdata1(rdata1), .ack0(ack0), .ack1(ack1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
    .cnt_gnt0(cnt_gnt0), .cnt_gnt1(cnt_gnt1), .cnt_conflict(cnt_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sync RAM: read data appears one cycle after mem_en/mem_addr.
  logic [31:0] mem [0:(1<<AW)-1];
  bit ram_loaded;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      mem[16]    <= 32'hDEADBEEF;
      ram_loaded <= 1'b1;
    end
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] rd_model[2];
  int          ack_at[8];
  logic        order[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"},   {30'd0, ack1, ack0}, 32'd0);
    chk({tag, "_mem"},   {30'd0, mem_en, mem_we}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_addr"},  {19'd0, mem_addr}, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_rd0"},   rdata0, 32'd0);
    chk({tag, "_rd1"},   rdata1, 32'd0);
    chk({tag, "_gnt0"},  cnt_gnt0, 32'd0);
    chk({tag, "_gnt1"},  cnt_gnt1, 32'd0);
    chk({tag, "_conf"},  cnt_conflict, 32'd0);
  endtask

  task automatic drive(input logic p, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (p) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
  endtask

  // One access on port p; returns read data, latency from request cycle, and absolute ack cycle.
  task automatic access(input logic p, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd,
                        output int lat, output int ack_cyc);
    int c0;
    @(negedge clk);
    drive(p, 1'b1, w, a, d);
    c0  = cyc;
    lat = -1;
    rd  = '0;
    ack_cyc = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      chk("other_ack", p ? {31'd0, ack0} : {31'd0, ack1}, 32'd0);
      if (p ? ack1 : ack0) begin
        lat     = cyc - c0;
        ack_cyc = cyc;
        rd      = p ? rdata1 : rdata0;
        drive(p, 1'b0, w, a, d);
      end
    end
    if (lat < 0) begin
      chk("ack_timeout", 32'd0, 32'd1);
      drive(p, 1'b0, w, a, d);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, exp;
    int lat, ackc, n, a0c, a1c;
    bit any_ack;

    vecs[0] = '{1'b0, 1'b1, 32'h0000_0008, 32'h1234_5678, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,         32'h1234_5678};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0100, 32'hA5A5_0F0F, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         32'hA5A5_0F0F};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h1234_5678};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_7FFC, 32'hCAFE_F00D, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_7FFC, 32'h0,         32'hCAFE_F00D};
    vecs[7] = '{1'b0, 1'b0, 32'h0001_0043, 32'h0,         32'hDEAD_BEEF};

    rst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // First access: port 1 read of 0x40.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("first_mem_en_c%0d", k), {31'd0, mem_en}, {31'd0, (k <= L)});
      chk($sformatf("first_ack1_c%0d", k), {31'd0, ack1}, {31'd0, (k == L + 1)});
      if (k == 1) chk("first_mem_addr", {19'd0, mem_addr}, 32'h10);
      if (k == L + 1) begin
        chk("first_rdata1", rdata1, 32'hDEADBEEF);
        req1 = 1'b0;
      end
    end
    chk("first_gnt1", cnt_gnt1, 32'd1);
    chk("first_gnt0", cnt_gnt0, 32'd0);

    // Table of single-port accesses; writes leave rdata unchanged.
    rd_model[0] = 32'h0;
    rd_model[1] = 32'hDEADBEEF;
    for (int i = 0; i < 8; i++) begin
      access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat, ackc);
      ack_at[i] = ackc;
      exp = vecs[i].we ? rd_model[vecs[i].port] : vecs[i].rdata;
      rd_model[vecs[i].port] = exp;
      chk($sformatf("vec%0d_lat", i), lat, L + 1);
      chk($sformatf("vec%0d_rdata", i), rd, exp);
    end
    chk("b2b_ack_gap", ack_at[1] - ack_at[0], L + 2);
    chk("vec_gnt0", cnt_gnt0, 32'd5);
    chk("vec_gnt1", cnt_gnt1, 32'd4);

    // Both ports held for four accesses: alternation starting with port 1.
    do_reset();
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h8, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
    n = 0;
    for (int k = 1; k <= 40 && n < 4; k++) begin
      @(negedge clk);
      chk("tie_both_ack", {31'd0, ack0 & ack1}, 32'd0);
      if (ack0 || ack1) begin
        order[n] = ack1;
        if (ack1) chk("tie_rdata1", rdata1, 32'hA5A5_0F0F);
        else      chk("tie_rdata0", rdata0, 32'h1234_5678);
        n++;
        if (n == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    if (n < 4) begin
      chk("tie_timeout", n, 4);
      req0 = 1'b0; req1 = 1'b0;
    end
    chk("tie_order0", {31'd0, order[0]}, 32'd1);
    chk("tie_order1", {31'd0, order[1]}, 32'd0);
    chk("tie_order2", {31'd0, order[2]}, 32'd1);
    chk("tie_order3", {31'd0, order[3]}, 32'd0);
    @(negedge clk);
    chk("tie_conflict", cnt_conflict, 32'd4);
    chk("tie_gnt0", cnt_gnt0, 32'd2);
    chk("tie_gnt1", cnt_gnt1, 32'd2);

    // Port 1 requests in cycle 2 of a port-0 access.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h8, 32'h0);
    a0c = -1; a1c = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 2) drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
      if (ack0) begin a0c = k; req0 = 1'b0; end
      if (ack1) begin a1c = k; req1 = 1'b0; end
    end
    chk("late_ack0_cycle", a0c, 4);
    chk("late_ack1_cycle", a1c, 9);
    chk("late_rdata1", rdata1, 32'hDEADBEEF);
    chk("late_conflict", cnt_conflict, 32'd4);
    chk("late_gnt0", cnt_gnt0, 32'd3);
    chk("late_gnt1", cnt_gnt1, 32'd3);

    // Reset pulsed in the second WAIT cycle of a write.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h200, 32'h1111_1111);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    req0 = 1'b0;
    #1;
    chk("rst_async_busy", {31'd0, busy}, 32'd0);
    chk("rst_async_mem_en", {31'd0, mem_en}, 32'd0);
    @(negedge clk);
    chk_zero("rst_mid");
    rst = 1'b0;
    any_ack = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ack0 || ack1) any_ack = 1'b1;
    end
    chk("rst_no_ack", {31'd0, any_ack}, 32'd0);
    access(1'b1, 1'b0, 32'h40, 32'h0, rd, lat, ackc);
    chk("rst_after_lat", lat, L + 1);
    chk("rst_after_rdata", rd, 32'hDEADBEEF);
    chk("rst_after_gnt1", cnt_gnt1, 32'd1);
    chk("rst_after_gnt0", cnt_gnt0, 32'd0);

    // Port 0 drops its write request mid-WAIT.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h300, 32'hBEEF_0001);
    ackc = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 2) req0 = 1'b0;
      if (ack0) ackc = k;
    end
    chk("drop_ack0_cycle", ackc, 4);
    chk("drop_mem_value", mem[13'h0C0], 32'hBEEF_0001);
    access(1'b1, 1'b0, 32'h300, 32'h0, rd, lat, ackc);
    chk("drop_readback", rd, 32'hBEEF_0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
